// File: rtl/bist_ctrl_pkg.sv
// Shared types, defaults and index-width helper for the BIST sequencer.
// Used by bist_control_seq (optional abort: BIST_CTRL_ABORT_EN).
package bist_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_INIT,
    S_RUN,
    S_SEEDS,
    S_FIN,
    S_DONE,
    S_REARM
  } bist_state_t;

  localparam int         DEF_N_PAT     = 10;
  localparam int         DEF_N_SEG     = 10;
  localparam logic [9:0] DEF_SEED_MASK = 10'b00_0010_0000;

  // Index ports stay at least one bit wide when a count is 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bist_pattern_counter.sv
// Two-level pattern/segment counter for the BIST sequencer.
// Clear dominates enable; both indices wrap together on the final pattern.
module bist_pattern_counter
  import bist_ctrl_pkg::*;
#(
  parameter  int N_PAT = DEF_N_PAT,
  parameter  int N_SEG = DEF_N_SEG,
  localparam int PW    = idx_w(N_PAT),
  localparam int SW    = idx_w(N_SEG)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic          o_pat_tc,
  output logic          o_seg_tc,
  output logic [PW-1:0] o_pat_idx,
  output logic [SW-1:0] o_seg_idx
);

  logic [PW-1:0] r_pat;
  logic [SW-1:0] r_seg;

  assign o_pat_tc  = (r_pat == PW'(N_PAT - 1));
  assign o_seg_tc  = (r_seg == SW'(N_SEG - 1));
  assign o_pat_idx = r_pat;
  assign o_seg_idx = r_seg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_pat <= '0;
      r_seg <= '0;
    end else if (i_en) begin
      if (o_pat_tc) begin
        r_pat <= '0;
        r_seg <= o_seg_tc ? '0 : r_seg + 1'b1;
      end else begin
        r_pat <= r_pat + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bist_control_seq.sv
// BIST session sequencer: START handshake, seeded segments, Moore outputs.
// Optional ABORT/ABORTED ports when BIST_CTRL_ABORT_EN is defined.
module bist_control_seq
  import bist_ctrl_pkg::*;
#(
  parameter  int               N_PAT     = DEF_N_PAT,
  parameter  int               N_SEG     = DEF_N_SEG,
  parameter  logic [N_SEG-1:0] SEED_MASK = N_SEG'(DEF_SEED_MASK),
  localparam int               PW        = idx_w(N_PAT),
  localparam int               SW        = idx_w(N_SEG)
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          START,
`ifdef BIST_CTRL_ABORT_EN
  input  logic          ABORT,
  output logic          ABORTED,
`endif
  output logic          INIT,
  output logic          RUNNING,
  output logic          OUT,
  output logic          SEED,
  output logic          FINISH,
  output logic          BIST_END,
  output logic [PW-1:0] PAT_IDX,
  output logic [SW-1:0] SEG_IDX
);

  bist_state_t   r_state;
  bist_state_t   w_nxt;
  logic          r_init;
  logic          r_run;
  logic          r_seed;
  logic          r_fin;
  logic          r_end;
  logic          w_pat_tc;
  logic          w_seg_tc;
  logic          w_abt;
  logic          w_clr;
  logic          w_en;
  logic          w_seed_nxt;
  logic [PW-1:0] w_pat;
  logic [SW-1:0] w_seg;

`ifdef BIST_CTRL_ABORT_EN
  logic r_abt;
  assign w_abt   = ABORT &
                   (r_state inside {S_INIT, S_RUN, S_SEEDS});
  assign ABORTED = r_abt;
`else
  assign w_abt = 1'b0;
`endif

  assign w_clr = (r_state == S_INIT) | (r_state == S_FIN) | w_abt;
  assign w_en  = (r_state == S_RUN);

  bist_pattern_counter #(
    .N_PAT (N_PAT),
    .N_SEG (N_SEG)
  ) u_cnt (
    .i_clk     (CLK),
    .i_rst_n   (RESET_N),
    .i_clr     (w_clr),
    .i_en      (w_en),
    .o_pat_tc  (w_pat_tc),
    .o_seg_tc  (w_seg_tc),
    .o_pat_idx (w_pat),
    .o_seg_idx (w_seg)
  );

  // Mask bit of the segment that follows the current one.
  always_comb begin
    w_seed_nxt = 1'b0;
    for (int k = 1; k < N_SEG; k++) begin
      if (w_seg == SW'(k - 1)) w_seed_nxt = SEED_MASK[k];
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (!START) w_nxt = S_ARM;
      S_ARM:   if (START) w_nxt = S_INIT;
      S_INIT:  w_nxt = SEED_MASK[0] ? S_SEEDS : S_RUN;
      S_RUN: begin
        if (w_pat_tc) begin
          if (w_seg_tc)        w_nxt = S_FIN;
          else if (w_seed_nxt) w_nxt = S_SEEDS;
        end
      end
      S_SEEDS: w_nxt = S_RUN;
      S_FIN:   w_nxt = S_DONE;
      S_DONE:  if (!START) w_nxt = S_REARM;
      S_REARM: if (START) w_nxt = S_INIT;
    endcase
    if (w_abt) w_nxt = S_DONE;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_init  <= 1'b0;
      r_run   <= 1'b0;
      r_seed  <= 1'b0;
      r_fin   <= 1'b0;
      r_end   <= 1'b0;
`ifdef BIST_CTRL_ABORT_EN
      r_abt   <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt;
      r_init  <= (w_nxt == S_INIT);
      r_run   <= (w_nxt == S_RUN);
      r_seed  <= (w_nxt == S_SEEDS);
      r_fin   <= (w_nxt == S_FIN);
      r_end   <= (w_nxt inside {S_FIN, S_DONE, S_REARM});
`ifdef BIST_CTRL_ABORT_EN
      if (w_nxt == S_INIT) r_abt <= 1'b0;
      else if (w_abt)      r_abt <= 1'b1;
`endif
    end
  end

  assign INIT     = r_init;
  assign RUNNING  = r_run;
  assign OUT      = r_run & ~w_pat_tc;
  assign SEED     = r_seed;
  assign FINISH   = r_fin;
  assign BIST_END = r_end;
  assign PAT_IDX  = w_pat;
  assign SEG_IDX  = w_seg;

endmodule

// File: tb/tb_bist_control_seq.sv
// Directed/randomised bench for bist_control_seq against a session model.
// Abort scenarios are exercised when BIST_CTRL_ABORT_EN is defined.
module tb_bist_control_seq;

  typedef struct packed {
    bit init;
    bit run;
    bit out;
    bit seed;
    bit fin;
    bit bend;
    bit abt;
    int pat;
    int seg;
  } obs_t;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic START = 1'b0;
  logic ABORT = 1'b0;

  logic init0, run0, out0, seed0, fin0, end0;
  logic [3:0] pat0, seg0;
  logic init1, run1, out1, seed1, fin1, end1;
  logic [1:0] pat1, seg1;
  logic init2, run2, out2, seed2, fin2, end2;
  logic [0:0] pat2, seg2;
  logic ab0, ab1, ab2;

  int n_chk = 0;
  int n_fail = 0;
  obs_t q[$];

  always #5 CLK = ~CLK;

  bist_control_seq u0 (
    .CLK(CLK), .RESET_N(RESET_N), .START(START),
`ifdef BIST_CTRL_ABORT_EN
    .ABORT(ABORT), .ABORTED(ab0),
`endif
    .INIT(init0), .RUNNING(run0), .OUT(out0), .SEED(seed0),
    .FINISH(fin0), .BIST_END(end0), .PAT_IDX(pat0), .SEG_IDX(seg0)
  );

  bist_control_seq #(.N_PAT(4), .N_SEG(3), .SEED_MASK(3'b101)) u1 (
    .CLK(CLK), .RESET_N(RESET_N), .START(START),
`ifdef BIST_CTRL_ABORT_EN
    .ABORT(ABORT), .ABORTED(ab1),
`endif
    .INIT(init1), .RUNNING(run1), .OUT(out1), .SEED(seed1),
    .FINISH(fin1), .BIST_END(end1), .PAT_IDX(pat1), .SEG_IDX(seg1)
  );

  bist_control_seq #(.N_PAT(2), .N_SEG(1), .SEED_MASK(1'b0)) u2 (
    .CLK(CLK), .RESET_N(RESET_N), .START(START),
`ifdef BIST_CTRL_ABORT_EN
    .ABORT(ABORT), .ABORTED(ab2),
`endif
    .INIT(init2), .RUNNING(run2), .OUT(out2), .SEED(seed2),
    .FINISH(fin2), .BIST_END(end2), .PAT_IDX(pat2), .SEG_IDX(seg2)
  );

`ifndef BIST_CTRL_ABORT_EN
  assign ab0 = 1'b0;
  assign ab1 = 1'b0;
  assign ab2 = 1'b0;
`endif

  function automatic obs_t get_obs(int d);
    obs_t o;
    o = '0;
    case (d)
      0: begin
        o.init = init0; o.run = run0; o.out = out0; o.seed = seed0;
        o.fin = fin0; o.bend = end0; o.abt = ab0;
        o.pat = int'(pat0); o.seg = int'(seg0);
      end
      1: begin
        o.init = init1; o.run = run1; o.out = out1; o.seed = seed1;
        o.fin = fin1; o.bend = end1; o.abt = ab1;
        o.pat = int'(pat1); o.seg = int'(seg1);
      end
      default: begin
        o.init = init2; o.run = run2; o.out = out2; o.seed = seed2;
        o.fin = fin2; o.bend = end2; o.abt = ab2;
        o.pat = int'(pat2); o.seg = int'(seg2);
      end
    endcase
    return o;
  endfunction

  task automatic chk(string t, int got, int exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", t, got, exp);
    end
  endtask

  task automatic cmp(string t, obs_t g, obs_t e);
    chk({t, " INIT"}, int'(g.init), int'(e.init));
    chk({t, " RUNNING"}, int'(g.run), int'(e.run));
    chk({t, " OUT"}, int'(g.out), int'(e.out));
    chk({t, " SEED"}, int'(g.seed), int'(e.seed));
    chk({t, " FINISH"}, int'(g.fin), int'(e.fin));
    chk({t, " BIST_END"}, int'(g.bend), int'(e.bend));
    chk({t, " PAT_IDX"}, g.pat, e.pat);
    chk({t, " SEG_IDX"}, g.seg, e.seg);
`ifdef BIST_CTRL_ABORT_EN
    chk({t, " ABORTED"}, int'(g.abt), int'(e.abt));
`endif
  endtask

  // Expected per-cycle view of one session, INIT through FIN.
  function automatic void build(int np, int ns, bit [9:0] mask);
    obs_t e;
    q.delete();
    e = '0; e.init = 1'b1;
    q.push_back(e);
    for (int s = 0; s < ns; s++) begin
      if (mask[s]) begin
        e = '0; e.seed = 1'b1; e.seg = s;
        q.push_back(e);
      end
      for (int p = 0; p < np; p++) begin
        e = '0; e.run = 1'b1; e.out = (p < np - 1);
        e.pat = p; e.seg = s;
        q.push_back(e);
      end
    end
    e = '0; e.fin = 1'b1; e.bend = 1'b1;
    q.push_back(e);
  endfunction

  task automatic run_session(int d, int np, int ns, bit [9:0] mask,
                             int abort_at, int reset_at);
    obs_t g;
    obs_t e;
    int n_out;
    string t;
    build(np, ns, mask);
    n_out = 0;
    START = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge CLK);
    START = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge CLK);
      g = get_obs(d);
      t = $sformatf("d%0d c%0d", d, i);
      cmp(t, g, q[i]);
      if (g.out) n_out++;
      if (i == reset_at) begin
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        cmp({t, " rst"}, get_obs(d), '0);
        repeat ($urandom_range(2, 4)) begin
          @(negedge CLK);
          cmp({t, " idle"}, get_obs(d), '0);
        end
        return;
      end
      if (i == abort_at) begin
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        e = '0; e.bend = 1'b1; e.abt = 1'b1;
        cmp({t, " abort"}, get_obs(d), e);
        repeat ($urandom_range(1, 3)) begin
          @(negedge CLK);
          cmp({t, " aborted"}, get_obs(d), e);
        end
        return;
      end
    end
    chk($sformatf("d%0d out_count", d), n_out, (np - 1) * ns);
    e = '0; e.bend = 1'b1;
    repeat ($urandom_range(2, 6)) begin
      @(negedge CLK);
      cmp($sformatf("d%0d hold", d), get_obs(d), e);
    end
  endtask

  initial begin
    RESET_N = 1'b0;
    START = 1'b1;
    repeat (3) @(negedge CLK);
    cmp("rst d0", get_obs(0), '0);
    cmp("rst d1", get_obs(1), '0);
    cmp("rst d2", get_obs(2), '0);
    RESET_N = 1'b1;
    repeat ($urandom_range(3, 6)) begin
      @(negedge CLK);
      cmp("start_high_idle", get_obs(0), '0);
    end

    run_session(0, 10, 10, 10'b00_0010_0000, -1, -1);
    run_session(0, 10, 10, 10'b00_0010_0000, -1, -1);
    run_session(1, 4, 3, 10'b101, -1, -1);
    run_session(2, 2, 1, 10'b0, -1, -1);

    START = 1'b1;
    repeat (110) @(negedge CLK);
    run_session(0, 10, 10, 10'b00_0010_0000, -1, 30);

`ifdef BIST_CTRL_ABORT_EN
    run_session(0, 10, 10, 10'b00_0010_0000, 20, -1);
    run_session(0, 10, 10, 10'b00_0010_0000, 101, -1);
    run_session(0, 10, 10, 10'b00_0010_0000,
                int'($urandom_range(0, 101)), -1);
    run_session(0, 10, 10, 10'b00_0010_0000, -1, -1);
`endif

    START = 1'b1;
    repeat (110) @(negedge CLK);
    run_session(1, 4, 3, 10'b101, -1, -1);
    run_session(2, 2, 1, 10'b0, -1, -1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/bist_control_seq.md
# bist_control_seq

Parametrised successor of the team's fixed 9×9 BIST sequencer. It drives a pattern generator / MISR pair through `N_SEG` segments of `N_PAT` patterns each. It issues a one-cycle reseed slot before any segment selected by a mask, and exposes live pattern/segment indices. It sits between the test-access START control and the LFSR/MISR datapath.

## Interface
- `N_PAT`, default 10: patterns per segment; legal range is ≥2.
- `N_SEG`, default 10: segments per session; legal range is ≥1.
- `SEED_MASK`, default `10'b00_0010_0000`: `N_SEG` bits; bit k=1 inserts a SEED cycle before segment k.
- `CLK` input, 1 bit: single clock; all state updates on its rising edge.
- `RESET_N` input, 1 bit: synchronous, active-low reset.
- `START` input, 1 bit: session request; rising-edge semantics are enforced by the FSM.
- `INIT` output, 1 bit: one-cycle pulse; datapath loads its initial seed and clears the MISR.
- `RUNNING` output, 1 bit: pattern cycle in progress.
- `OUT` output, 1 bit: capture enable; 1 on every pattern except the last pattern of each segment.
- `SEED` output, 1 bit: one-cycle reseed slot.
- `FINISH` output, 1 bit: one-cycle pulse at normal completion.
- `BIST_END` output, 1 bit: session complete; held until the next INIT.
- `PAT_IDX` output, `$clog2(N_PAT)` bits: current pattern index.
- `SEG_IDX` output, `$clog2(N_SEG)` bits: current segment index.
- `ABORT` input, 1 bit, and `ABORTED` output, 1 bit: present only when `BIST_CTRL_ABORT_EN` is defined (see Configuration).

## Operation
- States: IDLE, ARM, INIT, RUN, SEEDS, FIN, DONE, REARM.
- **IDLE:** if START=0, go to ARM.
- **ARM:** if START=1, go to INIT.
- **INIT:** one cycle.
  - INIT=1; `pat_cnt` and `seg_cnt` are cleared.
  - If SEED_MASK[0]=1, go to SEEDS; otherwise go to RUN.
- **RUN:** RUNNING=1.
  - OUT=1 when PAT_IDX < N_PAT-1.
  - OUT=0 on PAT_IDX = N_PAT-1 (the boundary cycle, used for the signature unload).
  - On a boundary cycle where SEG_IDX = N_SEG-1: go to FIN.
  - On any other boundary cycle: PAT_IDX wraps to 0 and SEG_IDX increments. Then go to SEEDS if SEED_MASK[SEG_IDX+1]=1, otherwise stay in RUN.
- **SEEDS:** one cycle.
  - SEED=1, RUNNING=0, counters hold; then go to RUN.
- **FIN:** one cycle.
  - FINISH=1, BIST_END=1; counters clear; then go to DONE.
- **DONE:** BIST_END=1; if START=0, go to REARM.
- **REARM:** BIST_END=1; if START=1, go to INIT.
- Outputs are Moore: decoded from the state register and the counters only. There is no combinational path from any input to any output.
- Any output not listed for a state is 0.
- START is ignored in INIT, RUN, SEEDS and FIN.

## Timing
- **Reset:** RESET_N=0 sampled at a CLK edge forces IDLE, counters to 0, and all outputs (including ABORTED) to 0. This applies from any state, including mid-RUN.
- **Start latency:** INIT is asserted in the first cycle after the edge that samples START=1 in ARM or REARM.
- **Session length:** with cycle 0 = INIT, the RUN+SEEDS span is N_PAT·N_SEG + popcount(SEED_MASK) cycles. FIN follows immediately after.
- **Defaults:** RUN occupies cycles 1–50, SEEDS is cycle 51, RUN occupies cycles 52–101, FIN is cycle 102, and BIST_END is held from cycle 102.
- **OUT count:** OUT is high for (N_PAT-1)·N_SEG cycles per session; 90 at defaults.
- **N_SEG=1:** SEED_MASK[0] is the only mask bit that can take effect.
- **START held high through DONE:** no restart. START must first be seen low (REARM) before a new session can begin.

## Configuration
- **`BIST_CTRL_ABORT_EN` defined:**
  - The ABORT input and ABORTED output exist.
  - ABORT=1 sampled in INIT, RUN or SEEDS sends the FSM to DONE on the next edge. Counters clear, FINISH is not pulsed, and BIST_END=1 and ABORTED=1 both hold.
  - ABORTED clears on the next INIT.
  - ABORT has priority over a simultaneous segment boundary or final boundary.
  - ABORT is ignored in every other state.
- **Macro undefined:** neither port exists; sequencing is exactly as described in Operation.

## Structure
- Package `bist_ctrl_pkg` holds:
  - the `bist_state_t` enum, which encodes the 8 states;
  - the default `N_PAT`, `N_SEG` and `SEED_MASK` constants;
  - an index-width helper function.
- Sub-module `bist_pattern_counter` is a two-level pattern/segment counter.
  - Controls: clear, enable (RUN only), parameters `N_PAT`/`N_SEG`.
  - Outputs: `pat_tc`, `seg_tc`, and both indices.
- The FSM lives in `bist_control_seq`.

## Test plan
- **Default run:** reset, START 0→1 → INIT at cycle 0; SEED only at cycle 51; FINISH at cycle 102; exactly 90 OUT cycles; BIST_END held afterwards.
- **START high at reset release:** no INIT until START is seen low then high. Holding START=1 after FINISH → no restart; dropping then raising START → new INIT with PAT_IDX=0 and SEG_IDX=0.
- **Edge mask, N_PAT=4, N_SEG=3, SEED_MASK=3'b101:** SEED cycles immediately after INIT and before segment 2; FINISH at cycle 15.
- **Reset mid-operation:** RESET_N=0 for 1 cycle at cycle 30 → all outputs 0 next cycle; FSM returns to IDLE.
- **Abort, macro defined:** ABORT=1 at cycle 20 → DONE next cycle with BIST_END=1, ABORTED=1 and no FINISH pulse. ABORT coincident with the cycle-101 final boundary also yields ABORTED=1 and no FINISH. The next INIT clears ABORTED.
- **Minimum config, N_PAT=2, N_SEG=1, mask 0:** one OUT cycle, FINISH at cycle 3.
